mem_ifetch_responder: RTL

- Memory-side responder to the fetcher's instruction-request interface.
- Accepts a one-cycle fetch request carrying a PC and reads four bytes over the byte-wide synchronous RAM port.
- Assembles the bytes little-endian and returns the word with a one-cycle ok pulse.
- Sits inside the memory controller behind an external arbiter that grants it the RAM port; honours drop requests issued on rollback.

---
 rtl/mem_ifetch_responder_if.sv | 26 ++
 rtl/mem_ifetch_responder.sv | 102 ++++++++++
 2 files changed

// File: rtl/mem_ifetch_responder_if.sv
// Fetch-request and byte-wide RAM port bundle of the instruction-fetch responder.
// The slave modport is the responder; the master modport is the fetcher/arbiter/RAM side.
interface mem_ifetch_responder_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  rdy_in;
  logic                  en_in;
  logic [31:0]           pc_in;
  logic                  drop_in;
  logic                  ok_out;
  logic [31:0]           inst_out;
  logic                  req_out;
  logic                  grant_in;
  logic [ADDR_WIDTH-1:0] mem_a_out;
  logic [7:0]            mem_din_in;

  modport slave (
    input  rdy_in, en_in, pc_in, drop_in, grant_in, mem_din_in,
    output ok_out, inst_out, req_out, mem_a_out
  );

  modport master (
    output rdy_in, en_in, pc_in, drop_in, grant_in, mem_din_in,
    input  ok_out, inst_out, req_out, mem_a_out
  );
endinterface

// File: rtl/mem_ifetch_responder.sv
// Memory-side instruction fetch responder: reads four bytes from a byte-wide
// synchronous RAM, assembles them little-endian and returns the word with an ok pulse.
module mem_ifetch_responder #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  mem_ifetch_responder_if.slave  bus
);

  typedef enum logic {IDLE, READ} state_t;

  state_t                state_q;
  logic [2:0]            cnt_q;
  logic                  resync_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [23:0]           bytes_q;
  logic [31:0]           inst_q;
  logic                  ok_q;
  logic                  req_q;
  logic [ADDR_WIDTH-1:0] mem_a_d;
  logic                  adv_d;

  // A byte is consumed only on an edge that really moves the burst forward.
  always_comb begin
    adv_d = bus.rdy_in && !bus.drop_in && (state_q == READ) && bus.grant_in && !resync_q;
  end

  // While paused, or replaying after a pause, re-present the previous byte address
  // so the RAM's registered output matches what the next advancing edge expects.
  always_comb begin
    mem_a_d = '0;
    if (state_q == READ) begin
      if ((!bus.rdy_in && (cnt_q != 3'd0)) || (bus.grant_in && resync_q)) begin
        mem_a_d = addr_q + ADDR_WIDTH'(cnt_q) - ADDR_WIDTH'(1);
      end else if (bus.grant_in && (cnt_q <= 3'd3)) begin
        mem_a_d = addr_q + ADDR_WIDTH'(cnt_q);
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q  <= IDLE;
      cnt_q    <= 3'd0;
      resync_q <= 1'b0;
      addr_q   <= '0;
      inst_q   <= '0;
      ok_q     <= 1'b0;
      req_q    <= 1'b0;
    end else if (!bus.rdy_in) begin
      // Only the pause marker moves while frozen; it forces one replay cycle afterwards.
      if ((state_q == READ) && (cnt_q != 3'd0)) begin
        resync_q <= 1'b1;
      end
    end else begin
      ok_q <= 1'b0;
      if (bus.drop_in) begin
        state_q  <= IDLE;
        cnt_q    <= 3'd0;
        resync_q <= 1'b0;
        req_q    <= 1'b0;
      end else if (state_q == IDLE) begin
        if (bus.en_in) begin
          addr_q  <= bus.pc_in[ADDR_WIDTH-1:0];
          cnt_q   <= 3'd0;
          req_q   <= 1'b1;
          state_q <= READ;
        end
      end else if (bus.grant_in) begin
        if (resync_q) begin
          resync_q <= 1'b0;
        end else if (cnt_q == 3'd4) begin
          inst_q  <= {bus.mem_din_in, bytes_q};
          ok_q    <= 1'b1;
          req_q   <= 1'b0;
          state_q <= IDLE;
          cnt_q   <= 3'd0;
        end else begin
          cnt_q <= cnt_q + 3'd1;
        end
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (adv_d) begin
      case (cnt_q)
        3'd1:    bytes_q[7:0]   <= bus.mem_din_in;
        3'd2:    bytes_q[15:8]  <= bus.mem_din_in;
        3'd3:    bytes_q[23:16] <= bus.mem_din_in;
        default: ;
      endcase
    end
  end

  assign bus.ok_out    = ok_q;
  assign bus.inst_out  = inst_q;
  assign bus.req_out   = req_q;
  assign bus.mem_a_out = mem_a_d;

endmodule
